// File: rtl/clk_reset_sequencer_if.sv
// Reset sequencer signal bundle.
// Sequencer drives the staged resets; the board side drives lock and button.
interface clk_reset_sequencer_if;
    logic       pll_lock;
    logic       btn_rst_n;
    logic       periph_rst_n;
    logic       cpu_rst_n;
    logic       ready;
    logic [1:0] rst_cause;

    modport master (
        input  pll_lock,
        input  btn_rst_n,
        output periph_rst_n,
        output cpu_rst_n,
        output ready,
        output rst_cause
    );

    modport slave (
        output pll_lock,
        output btn_rst_n,
        input  periph_rst_n,
        input  cpu_rst_n,
        input  ready,
        input  rst_cause
    );
endinterface

// File: rtl/clk_reset_sequencer.sv
// Staged reset generator behind the PLL.
// Waits for stable lock, releases peripherals then CPU, tracks reset cause.
module clk_reset_sequencer #(
    parameter int LOCK_CYCLES     = 1024,
    parameter int STAGE_GAP       = 16,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input logic                   clk,
    input logic                   rst_n,
    clk_reset_sequencer_if.master bus
);

    localparam int DW   = $clog2(DEBOUNCE_CYCLES);
    localparam int SMAX = (LOCK_CYCLES > STAGE_GAP) ? LOCK_CYCLES : STAGE_GAP;
    localparam int SW   = $clog2(SMAX);

    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0] LOCK_LAST = SW'(LOCK_CYCLES - 1);
    localparam logic [SW-1:0] GAP_LAST  = SW'(STAGE_GAP - 1);

    localparam logic [1:0] CAUSE_POR  = 2'b00;
    localparam logic [1:0] CAUSE_LOCK = 2'b01;
    localparam logic [1:0] CAUSE_BTN  = 2'b10;

    typedef enum logic [2:0] {
        WAIT_LOCK,
        COUNT,
        STAGE,
        RUN,
        BTN_HOLD
    } state_t;

    logic          lock_m;
    logic          lock_s;
    logic          btn_m;
    logic          btn_s;
    logic          btn_db;
    logic [DW-1:0] db_cnt;

    state_t        state;
    state_t        state_d;
    logic [SW-1:0] seq_cnt;
    logic [SW-1:0] seq_cnt_d;
    logic [1:0]    cause;
    logic [1:0]    cause_d;
    logic          locked_state;

    logic          periph_q;
    logic          cpu_q;
    logic          ready_q;
    logic          periph_d;
    logic          cpu_d;

    // Two-flop synchronizers; lock idles unlocked, button idles released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
            btn_m  <= 1'b1;
            btn_s  <= 1'b1;
        end else begin
            lock_m <= bus.pll_lock;
            lock_s <= lock_m;
            btn_m  <= bus.btn_rst_n;
            btn_s  <= btn_m;
        end
    end

    // Debounced level follows btn_s only after it has differed long enough.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt <= '0;
            btn_db <= 1'b1;
        end else if (btn_s == btn_db) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            db_cnt <= '0;
            btn_db <= btn_s;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    assign locked_state = (state == COUNT) ||
                          (state == STAGE) ||
                          (state == RUN);

    // Next state, cause update and shared counter; button beats lock loss.
    always_comb begin
        state_d   = state;
        cause_d   = cause;
        seq_cnt_d = '0;

        case (state)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (seq_cnt == LOCK_LAST) begin
                    state_d = STAGE;
                end
            end
            STAGE: begin
                if (seq_cnt == GAP_LAST) begin
                    state_d = RUN;
                end
            end
            BTN_HOLD: begin
                if (btn_db) begin
                    state_d = WAIT_LOCK;
                end
            end
            default: begin
                state_d = state;
            end
        endcase

        if ((state != BTN_HOLD) && !btn_db) begin
            state_d = BTN_HOLD;
            cause_d = CAUSE_BTN;
        end else if (locked_state && !lock_s) begin
            state_d = WAIT_LOCK;
            cause_d = CAUSE_LOCK;
        end

        if (state_d != state) begin
            seq_cnt_d = '0;
        end else if ((state == COUNT) || (state == STAGE)) begin
            seq_cnt_d = seq_cnt + 1'b1;
        end
    end

    // Reset outputs decoded from the upcoming state so they are registered.
    always_comb begin
        periph_d = (state_d == STAGE) || (state_d == RUN);
        cpu_d    = (state_d == RUN);
    end

    // State, counter and cause registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= WAIT_LOCK;
            seq_cnt <= '0;
            cause   <= CAUSE_POR;
        end else begin
            state   <= state_d;
            seq_cnt <= seq_cnt_d;
            cause   <= cause_d;
        end
    end

    // Output registers; power-on reset forces everything asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            periph_q <= 1'b0;
            cpu_q    <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            periph_q <= periph_d;
            cpu_q    <= cpu_d;
            ready_q  <= cpu_d;
        end
    end

    assign bus.periph_rst_n = periph_q;
    assign bus.cpu_rst_n    = cpu_q;
    assign bus.ready        = ready_q;
    assign bus.rst_cause    = cause;

endmodule

// File: doc/clk_reset_sequencer.md
# clk_reset_sequencer

Sits directly downstream of the ECP5 PLL wrapper and generates the system's staged resets. It takes the PLL output clock and asynchronous lock indication, plus the board reset button, and holds the design in reset until the clock has been stable for a programmable time. It then releases peripheral reset first and CPU reset a fixed gap later, re-asserting both on lock loss or on a debounced button press. It records the cause of the most recent reset.

## Interface
- LOCK_CYCLES, 1024: consecutive cycles with synchronized lock high before peripheral release (≥2).
- STAGE_GAP, 16: cycles between peripheral release and CPU release (≥2).
- DEBOUNCE_CYCLES, 65536: consecutive stable cycles required before the debounced button level changes (≥2).
- clk  in  1  PLL output clock; the only clock.
- rst_n  in  1  Asynchronous, active-low reset (power-on).
- pll_lock  in  1  PLL lock, asynchronous to clk.
- btn_rst_n  in  1  Pushbutton, active-low, asynchronous, bouncy.
- periph_rst_n  out  1  Peripheral reset, active-low.
- cpu_rst_n  out  1  CPU reset, active-low.
- ready  out  1  High only in RUN.
- rst_cause  out  2  Cause of most recent reset: 00 power-on, 01 lock lost, 10 button.

## Operation
- Synchronizers: pll_lock and btn_rst_n each pass through two flops, giving lock_s and btn_s. Both flops reset to 0 for lock and to 1 for the button.
- Debouncer:
  - The counter increments while btn_s differs from btn_db and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 and btn_s still differs, btn_db takes btn_s on the next edge.
  - btn_db resets to 1.
  - Counter width is $clog2(DEBOUNCE_CYCLES).
- Shared sequence counter: width $clog2(max(LOCK_CYCLES,STAGE_GAP)). It clears on every state entry.
- FSM states: WAIT_LOCK (reset state), COUNT, STAGE, RUN, BTN_HOLD.
  - WAIT_LOCK: when lock_s=1, go to COUNT.
  - COUNT: the counter increments each cycle. At count==LOCK_CYCLES-1, go to STAGE.
  - STAGE: the counter increments. At count==STAGE_GAP-1, go to RUN.
  - RUN: hold.
  - Any state except BTN_HOLD, with btn_db=0: go to BTN_HOLD and set cause=10. Button has priority over lock loss in the same cycle.
  - COUNT, STAGE or RUN, with lock_s=0 and btn_db=1: go to WAIT_LOCK and set cause=01.
  - BTN_HOLD: when btn_db=1, go to WAIT_LOCK; cause stays 10.
- Outputs are registered and decoded from the next state:
  - periph_rst_n=1 in STAGE and RUN.
  - cpu_rst_n=1 and ready=1 in RUN only.
- rst_n low: asynchronously forces state WAIT_LOCK, periph_rst_n=0, cpu_rst_n=0, ready=0, rst_cause=00, counters 0. Applies mid-sequence too.
- rst_cause changes only on the events above; it persists through the subsequent release.

## Timing
- All outputs assert (go low) at the edge where the FSM leaves the released state; there is no combinational path from inputs to outputs.
- Deassertion is always synchronous to clk.
- Edge numbering: pll_lock first sampled high at edge 1.
  - lock_s=1 after edge 2.
  - COUNT entered at edge 3.
  - periph_rst_n rises at edge LOCK_CYCLES+3.
  - cpu_rst_n and ready rise at edge LOCK_CYCLES+STAGE_GAP+3.
- Lock loss: pll_lock sampled low at edge n gives periph_rst_n, cpu_rst_n and ready all low after edge n+2.
- Button: btn_rst_n sampled low at edge 1 and held gives btn_db=0 after edge DEBOUNCE_CYCLES+2, and resets low after edge DEBOUNCE_CYCLES+3.
- A low pulse on btn_s shorter than DEBOUNCE_CYCLES cycles is ignored.
- Lock loss while in BTN_HOLD is ignored. After button release, the sequence restarts from WAIT_LOCK with the full LOCK_CYCLES count.
- A lock dropout of even one synchronized cycle during COUNT restarts the count from 0.

## Test plan
Bench parameters: LOCK_CYCLES=8, STAGE_GAP=4, DEBOUNCE_CYCLES=4.
- Power-on: rst_n low, pll_lock=1 → all outputs 0, rst_cause=00. After rst_n is released with pll_lock already 1, periph_rst_n rises at edge 11 and cpu_rst_n/ready rise at edge 15.
- Lock glitch during COUNT: pll_lock low for 1 cycle at edge 6 → outputs stay low. The count restarts and periph_rst_n rises 11 edges after lock returns.
- Lock loss in RUN: pll_lock falls → all outputs 0 two edges later, rst_cause=01. Re-lock repeats the staged release exactly.
- Button bounce: 3-cycle low pulses repeated → no reset. A held press → resets low after edge 7, rst_cause=10, held until release is debounced, then 8+4 staged release.
- Simultaneous button and lock loss in RUN → BTN_HOLD, rst_cause=10.
- rst_n asserted in STAGE → outputs 0 immediately (asynchronously), rst_cause=00, FSM in WAIT_LOCK.
